// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with byte-enabled writes, write-first bypass,
// and a per-register pending scoreboard used by decode for RAW stall detection.
`timescale 1ns/1ps
module regfile_mp_sb #(
    parameter int  DATA_W   = 32,
    parameter int  ADDR_W   = 5,
    parameter int  NUM_RD   = 2,
    parameter int  ZERO_REG = 1,
    localparam int BE_W     = DATA_W / 8,
    localparam int DEPTH    = 2 ** ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [BE_W-1:0]          wr_be,
    input  logic                     mark_en,
    input  logic [ADDR_W-1:0]        mark_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_next;
    logic [ADDR_W:0]   cnt_next;
    logic              wr_ok;
    logic              mark_ok;

    assign wr_ok   = wr_en   && !((ZERO_REG != 0) && (wr_addr == '0));
    assign mark_ok = mark_en && !((ZERO_REG != 0) && (mark_addr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) begin
                    regs[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Each port merges the in-flight writeback so decode sees the value and
    // the hazard resolved in the same cycle the writeback happens.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] word;
        logic              hit;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];
        assign hit  = wr_en && (wr_addr == addr);

        always_comb begin
            word = regs[addr];
            if (hit) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (wr_be[b]) begin
                        word[8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                word = '0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = word;
        assign rd_pend[k] = pend[addr] && !hit;
    end

    // Flush first, then writeback clears, then mark sets: a new producer
    // always wins over a retiring one on the same register.
    always_comb begin
        pend_next = flush ? '0 : pend;
        if (wr_en) begin
            pend_next[wr_addr] = 1'b0;
        end
        if (mark_ok) begin
            pend_next[mark_addr] = 1'b1;
        end
    end

    always_comb begin
        cnt_next = pend_cnt;
        if (flush) begin
            cnt_next = mark_ok ? CNT_ONE : '0;
        end else begin
            if (mark_ok && !pend[mark_addr]) begin
                cnt_next = cnt_next + CNT_ONE;
            end
            if (wr_en && pend[wr_addr] && !(mark_ok && (mark_addr == wr_addr))) begin
                cnt_next = cnt_next - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_next;
            pend_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a default 32-bit/2-port instance and a
// 64-bit/4-port instance driven side by side with hand-computed expectations.
`timescale 1ns/1ps
module tb_regfile_mp_sb;

    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2*AW-1:0] rd_addr_a;
    logic [63:0]     rd_data_a;
    logic [1:0]      rd_pend_a;
    logic            wr_en_a;
    logic [AW-1:0]   wr_addr_a;
    logic [31:0]     wr_data_a;
    logic [3:0]      wr_be_a;
    logic            mark_en_a;
    logic [AW-1:0]   mark_addr_a;
    logic            flush_a;
    logic [AW:0]     pend_cnt_a;

    logic [4*AW-1:0] rd_addr_b;
    logic [255:0]    rd_data_b;
    logic [3:0]      rd_pend_b;
    logic            wr_en_b;
    logic [AW-1:0]   wr_addr_b;
    logic [63:0]     wr_data_b;
    logic [7:0]      wr_be_b;
    logic            mark_en_b;
    logic [AW-1:0]   mark_addr_b;
    logic            flush_b;
    logic [AW:0]     pend_cnt_b;

    int checks = 0;
    int errors = 0;

    regfile_mp_sb u_dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr_a),
        .rd_data   (rd_data_a),
        .rd_pend   (rd_pend_a),
        .wr_en     (wr_en_a),
        .wr_addr   (wr_addr_a),
        .wr_data   (wr_data_a),
        .wr_be     (wr_be_a),
        .mark_en   (mark_en_a),
        .mark_addr (mark_addr_a),
        .flush     (flush_a),
        .pend_cnt  (pend_cnt_a)
    );

    regfile_mp_sb #(.DATA_W(64), .ADDR_W(AW), .NUM_RD(4), .ZERO_REG(1)) u_dut_wide (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr_b),
        .rd_data   (rd_data_b),
        .rd_pend   (rd_pend_b),
        .wr_en     (wr_en_b),
        .wr_addr   (wr_addr_b),
        .wr_data   (wr_data_b),
        .wr_be     (wr_be_b),
        .mark_en   (mark_en_b),
        .mark_addr (mark_addr_b),
        .flush     (flush_b),
        .pend_cnt  (pend_cnt_b)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa,
                                 input logic [31:0] wd, input logic [3:0] be,
                                 input logic me, input logic [AW-1:0] ma,
                                 input logic fl);
        wr_en_a     = we;
        wr_addr_a   = wa;
        wr_data_a   = wd;
        wr_be_a     = be;
        mark_en_a   = me;
        mark_addr_a = ma;
        flush_a     = fl;
    endtask

    task automatic applyStimulusWide(input logic we, input logic [AW-1:0] wa,
                                     input logic [63:0] wd, input logic [7:0] be,
                                     input logic me, input logic [AW-1:0] ma,
                                     input logic fl);
        wr_en_b     = we;
        wr_addr_b   = wa;
        wr_data_b   = wd;
        wr_be_b     = be;
        mark_en_b   = me;
        mark_addr_b = ma;
        flush_b     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleAll();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
        applyStimulusWide(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        rd_addr_a = '0;
        rd_addr_b = '0;
        idleAll();
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("reset_rd_data", rd_data_a, 64'h0);
        checkOutput("reset_rd_pend", {62'h0, rd_pend_a}, 64'h0);
        checkOutput("reset_pend_cnt", {58'h0, pend_cnt_a}, 64'h0);
        checkOutput("reset_wide_cnt", {58'h0, pend_cnt_b}, 64'h0);

        // Load r5, mark r6, then pulse reset between edges
        applyStimulus(1'b1, 5'd5, 32'hFFF12345, 4'hF, 1'b1, 5'd6, 1'b0);
        tick();
        idleAll();
        rd_addr_a = {5'd6, 5'd5};
        #1;
        checkOutput("load_r5", {32'h0, rd_data_a[31:0]}, 64'hFFF12345);
        checkOutput("mark_r6_pend", {62'h0, rd_pend_a}, 64'h2);
        checkOutput("mark_r6_cnt", {58'h0, pend_cnt_a}, 64'h1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_data", {32'h0, rd_data_a[31:0]}, 64'h0);
        checkOutput("async_rst_pend", {62'h0, rd_pend_a}, 64'h0);
        checkOutput("async_rst_cnt", {58'h0, pend_cnt_a}, 64'h0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_r5", {32'h0, rd_data_a[31:0]}, 64'h0);

        // Byte-enabled write and zero register
        applyStimulus(1'b1, 5'd8, 32'h7FF32432, 4'hF, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd8, 32'hAABBCCDD, 4'b0101, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b0, '0, 1'b0);
        rd_addr_a = {5'd0, 5'd8};
        #1;
        checkOutput("byte_write_r8", {32'h0, rd_data_a[31:0]}, 64'h7FBB24DD);
        checkOutput("r0_bypass_zero", {32'h0, rd_data_a[63:32]}, 64'h0);
        tick();
        idleAll();
        #1;
        checkOutput("r0_stays_zero", {32'h0, rd_data_a[63:32]}, 64'h0);

        // Write-first bypass on both ports
        applyStimulus(1'b1, 5'd15, 32'h45349592, 4'hF, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd15, 32'h11223344, 4'b1100, 1'b0, '0, 1'b0);
        rd_addr_a = {5'd15, 5'd15};
        #1;
        checkOutput("bypass_port0", {32'h0, rd_data_a[31:0]}, 64'h11229592);
        checkOutput("bypass_port1", {32'h0, rd_data_a[63:32]}, 64'h11229592);
        tick();
        idleAll();
        #1;
        checkOutput("bypass_stored", {32'h0, rd_data_a[31:0]}, 64'h11229592);

        // Scoreboard mark / writeback / simultaneous mark+write
        rd_addr_a = {5'd0, 5'd3};
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd3, 1'b0);
        tick();
        idleAll();
        #1;
        checkOutput("mark_r3_pend", {62'h0, rd_pend_a}, 64'h1);
        checkOutput("mark_r3_cnt", {58'h0, pend_cnt_a}, 64'h1);
        applyStimulus(1'b1, 5'd3, 32'h0, 4'h0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("wb_r3_same_cycle", {62'h0, rd_pend_a}, 64'h0);
        tick();
        idleAll();
        #1;
        checkOutput("wb_r3_cnt", {58'h0, pend_cnt_a}, 64'h0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd3, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd3, 32'h0, 4'h0, 1'b1, 5'd3, 1'b0);
        #1;
        checkOutput("mark_wb_comb", {62'h0, rd_pend_a}, 64'h0);
        tick();
        idleAll();
        #1;
        checkOutput("mark_wb_pend", {62'h0, rd_pend_a}, 64'h1);
        checkOutput("mark_wb_cnt", {58'h0, pend_cnt_a}, 64'h1);
        applyStimulus(1'b1, 5'd3, 32'h0, 4'h0, 1'b0, '0, 1'b0);
        tick();
        idleAll();

        // Flush with concurrent mark
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd1, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd2, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd4, 1'b0);
        tick();
        idleAll();
        #1;
        checkOutput("three_marks_cnt", {58'h0, pend_cnt_a}, 64'h3);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd7, 1'b1);
        tick();
        idleAll();
        rd_addr_a = {5'd1, 5'd7};
        #1;
        checkOutput("flush_mark_cnt", {58'h0, pend_cnt_a}, 64'h1);
        checkOutput("flush_mark_pend", {62'h0, rd_pend_a}, 64'h1);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd0, 1'b0);
        tick();
        idleAll();
        rd_addr_a = {5'd7, 5'd0};
        #1;
        checkOutput("mark_r0_cnt", {58'h0, pend_cnt_a}, 64'h1);
        checkOutput("mark_r0_pend", {62'h0, rd_pend_a}, 64'h2);
        applyStimulus(1'b1, 5'd7, 32'h0, 4'h0, 1'b0, '0, 1'b0);
        tick();
        idleAll();

        // Wide instance: 8 byte enables across four ports
        applyStimulusWide(1'b1, 5'd9, 64'h0123456789ABCDEF, 8'hFF, 1'b0, '0, 1'b0);
        tick();
        applyStimulusWide(1'b1, 5'd9, 64'hFEDCBA9876543210, 8'b10100101, 1'b0, '0, 1'b0);
        rd_addr_b = {5'd9, 5'd0, 5'd9, 5'd9};
        #1;
        checkOutput("wide_bypass_p0", rd_data_b[63:0], 64'hFE23BA678954CD10);
        checkOutput("wide_bypass_p3", rd_data_b[255:192], 64'hFE23BA678954CD10);
        tick();
        idleAll();
        #1;
        checkOutput("wide_stored_p1", rd_data_b[127:64], 64'hFE23BA678954CD10);
        checkOutput("wide_zero_p2", rd_data_b[191:128], 64'h0);

        // Fill every register on both instances, then retire them all
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'(i), 1'b0);
            applyStimulusWide(1'b0, '0, '0, '0, 1'b1, 5'(i), 1'b0);
            tick();
            if (i == 10) checkOutput("fill_mid_cnt", {58'h0, pend_cnt_a}, 64'd10);
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd0, 1'b0);
        applyStimulusWide(1'b0, '0, '0, '0, 1'b1, 5'd0, 1'b0);
        tick();
        idleAll();
        rd_addr_b = {5'd31, 5'd3, 5'd2, 5'd1};
        #1;
        checkOutput("fill_full_cnt", {58'h0, pend_cnt_a}, 64'd31);
        checkOutput("fill_wide_cnt", {58'h0, pend_cnt_b}, 64'd31);
        checkOutput("fill_wide_pend", {60'h0, rd_pend_b}, 64'hF);
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i), '0, 4'h0, 1'b0, '0, 1'b0);
            applyStimulusWide(1'b1, 5'(i), '0, 8'h0, 1'b0, '0, 1'b0);
            tick();
            if (i == 16) checkOutput("drain_mid_cnt", {58'h0, pend_cnt_b}, 64'd15);
        end
        idleAll();
        #1;
        checkOutput("drain_cnt", {58'h0, pend_cnt_a}, 64'h0);
        checkOutput("drain_wide_cnt", {58'h0, pend_cnt_b}, 64'h0);
        checkOutput("drain_wide_pend", {60'h0, rd_pend_b}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
